// File: rtl/edge_adaptive_binarize_pkg.sv
// Shared pixel types, binary output levels and threshold-update FSM states
// for the adaptive binarizer.
package img_pkg;

    typedef logic [7:0] pixel_t;

    localparam pixel_t BIN_FG = 8'hFF;
    localparam pixel_t BIN_BG = 8'h00;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        UPDATE = 2'd2
    } bin_state_t;

    // 9-bit add so that an overflow clamps to full scale instead of wrapping.
    function automatic pixel_t clamp_add(input pixel_t a, input pixel_t b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

endpackage

// File: rtl/edge_adaptive_binarize_if.sv
// Video timing stream (vsync/href/pixel) shared by the edge stage, the
// binarizer and whatever consumes the binary image.
interface edge_adaptive_binarize_if;
    import img_pkg::*;

    logic   vsync;
    logic   href;
    pixel_t pix;

    modport master (output vsync, output href, output pix);
    modport slave  (input  vsync, input  href, input  pix);

endinterface

// File: rtl/edge_adaptive_binarize_frame_mean_acc.sv
// Per-frame magnitude accumulator: tracks the mean of the last complete frame
// and turns it into the next adaptive threshold.
//
// state  | meaning
// IDLE   | waiting for vsync to rise
// ACTIVE | frame in progress, accumulating href pixels
// UPDATE | frame just ended, load new threshold or flag a bad pixel count
module frame_mean_acc
    import img_pkg::*;
#(
    parameter int     IMG_H_DISP = 512,
    parameter int     IMG_V_DISP = 512,
    parameter pixel_t INIT_THR   = 8'd128
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   vsync_i,
    input  logic   href_i,
    input  pixel_t gray_i,
    input  pixel_t cfg_offset_i,
    output pixel_t thr_cur_o,
    output logic   frame_err_o
);

    localparam int NPIX  = IMG_H_DISP * IMG_V_DISP;
    localparam int SHIFT = $clog2(NPIX);
    localparam int SUM_W = 8 + SHIFT;
    localparam int CNT_W = SHIFT + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NPIX);

    bin_state_t       state_q;
    logic             vsync_q;
    logic [SUM_W-1:0] sum_q;
    logic [CNT_W-1:0] cnt_q;
    pixel_t           thr_q;
    logic             err_q;

    logic             rise;
    logic             fall;
    logic [SUM_W-1:0] gray_ext;
    logic [CNT_W-1:0] cnt_inc;
    pixel_t           mean;
    pixel_t           new_thr;

    assign rise     = vsync_i & ~vsync_q;
    assign fall     = ~vsync_i & vsync_q;
    assign gray_ext = SUM_W'(gray_i);
    // Saturate so an over-long frame can never wrap back onto the exact count.
    assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    assign mean     = sum_q[SUM_W-1:SHIFT];
    assign new_thr  = clamp_add(mean, cfg_offset_i);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            vsync_q <= 1'b0;
            sum_q   <= '0;
            cnt_q   <= '0;
            thr_q   <= INIT_THR;
            err_q   <= 1'b0;
        end else begin
            vsync_q <= vsync_i;
            err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        sum_q   <= href_i ? gray_ext : '0;
                        cnt_q   <= href_i ? CNT_W'(1) : '0;
                        state_q <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (fall) begin
                        state_q <= UPDATE;
                    end else if (href_i) begin
                        sum_q <= sum_q + gray_ext;
                        cnt_q <= cnt_inc;
                    end
                end
                UPDATE: begin
                    if (cnt_q == CNT_FULL) begin
                        thr_q <= new_thr;
                    end else begin
                        err_q <= 1'b1;
                    end
                    sum_q   <= '0;
                    cnt_q   <= '0;
                    state_q <= vsync_i ? ACTIVE : IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign thr_cur_o   = thr_q;
    assign frame_err_o = err_q;

endmodule

// File: rtl/edge_adaptive_binarize.sv
// Binarizes the edge-magnitude stream against a fixed or frame-adaptive
// threshold with one cycle of latency on all timing signals.
module edge_adaptive_binarize
    import img_pkg::*;
#(
    parameter int     IMG_H_DISP = 512,
    parameter int     IMG_V_DISP = 512,
    parameter pixel_t INIT_THR   = 8'd128
) (
    input  logic                            clk,
    input  logic                            rst,
    edge_adaptive_binarize_if.slave         per_img,
    edge_adaptive_binarize_if.master        post_img,
    input  pixel_t                          cfg_offset_i,
    input  logic                            cfg_fixed_en_i,
    input  pixel_t                          cfg_fixed_thr_i,
    output pixel_t                          thr_cur_o,
    output logic                            frame_err_o
);

    localparam int NPIX = IMG_H_DISP * IMG_V_DISP;

    // mean = sum >> SHIFT is only exact when the pixel count is a power of two
    if ((NPIX & (NPIX - 1)) != 0) begin : g_npix_chk
        $error("IMG_H_DISP*IMG_V_DISP must be a power of two");
    end

    pixel_t thr_cur;
    pixel_t thr_sel;
    logic   vsync_q;
    logic   href_q;
    pixel_t bin_q;
    pixel_t bin_d;

    frame_mean_acc #(
        .IMG_H_DISP (IMG_H_DISP),
        .IMG_V_DISP (IMG_V_DISP),
        .INIT_THR   (INIT_THR)
    ) u_acc (
        .clk          (clk),
        .rst          (rst),
        .vsync_i      (per_img.vsync),
        .href_i       (per_img.href),
        .gray_i       (per_img.pix),
        .cfg_offset_i (cfg_offset_i),
        .thr_cur_o    (thr_cur),
        .frame_err_o  (frame_err_o)
    );

    assign thr_sel = cfg_fixed_en_i ? cfg_fixed_thr_i : thr_cur;

    always_comb begin
        bin_d = BIN_BG;
        if (per_img.href && (per_img.pix > thr_sel)) begin
            bin_d = BIN_FG;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            bin_q   <= BIN_BG;
        end else begin
            vsync_q <= per_img.vsync;
            href_q  <= per_img.href;
            bin_q   <= bin_d;
        end
    end

    assign post_img.vsync = vsync_q;
    assign post_img.href  = href_q;
    assign post_img.pix   = bin_q;
    assign thr_cur_o      = thr_cur;

endmodule

// File: tb/tb_edge_adaptive_binarize.sv
// Directed-vector bench for edge_adaptive_binarize on an 8x8 frame: the driver
// queues hand-computed expected pixels, a negedge monitor pops and checks them.
module tb_edge_adaptive_binarize;
    import img_pkg::*;

    logic   clk = 1'b0;
    logic   rst;
    pixel_t cfg_offset;
    logic   cfg_fixed_en;
    pixel_t cfg_fixed_thr;
    pixel_t thr_cur;
    logic   frame_err;

    always #5 clk = ~clk;

    edge_adaptive_binarize_if in_if ();
    edge_adaptive_binarize_if out_if ();

    edge_adaptive_binarize #(
        .IMG_H_DISP (8),
        .IMG_V_DISP (8),
        .INIT_THR   (8'd128)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .per_img         (in_if),
        .post_img        (out_if),
        .cfg_offset_i    (cfg_offset),
        .cfg_fixed_en_i  (cfg_fixed_en),
        .cfg_fixed_thr_i (cfg_fixed_thr),
        .thr_cur_o       (thr_cur),
        .frame_err_o     (frame_err)
    );

    typedef struct {
        int     cyc;
        logic   vs;
        pixel_t bin;
    } exp_t;

    exp_t sb[$];
    int   cyc     = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
        end
    endtask

    // Scoreboard monitor: every output pixel must match the next queued entry.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (out_if.href) begin
            if (sb.size() == 0) begin
                chk("unexpected_pixel", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("pix_cycle", cyc, e.cyc);
                chk("pix_vsync", int'(out_if.vsync), int'(e.vs));
                chk("pix_bin", int'(out_if.pix), int'(e.bin));
            end
        end else begin
            chk("bin_idle_zero", int'(out_if.pix), 0);
        end
    end

    task automatic drive(input logic vs, input logic hr, input pixel_t g, input pixel_t eb);
        exp_t e;
        in_if.vsync = vs;
        in_if.href  = hr;
        in_if.pix   = g;
        if (hr && !rst) begin
            e.cyc = cyc + 1;
            e.vs  = vs;
            e.bin = eb;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic frame(input pixel_t p0, input pixel_t p1,
                         input pixel_t e0, input pixel_t e1, input int npix);
        drive(1'b1, 1'b0, 8'h00, 8'h00);
        for (int i = 0; i < npix; i++) begin
            if ((i % 2) != 0) drive(1'b1, 1'b1, p1, e1);
            else              drive(1'b1, 1'b1, p0, e0);
            if ((i % 8) == 7) drive(1'b1, 1'b0, 8'h00, 8'h00);
        end
    endtask

    task automatic end_frame(input pixel_t thr_old, input pixel_t thr_new, input logic err);
        drive(1'b0, 1'b0, 8'h00, 8'h00);
        chk("thr_hold", int'(thr_cur), int'(thr_old));
        chk("err_early", int'(frame_err), 0);
        drive(1'b0, 1'b0, 8'h00, 8'h00);
        chk("thr_update", int'(thr_cur), int'(thr_new));
        chk("frame_err", int'(frame_err), int'(err));
        drive(1'b0, 1'b0, 8'h00, 8'h00);
        chk("err_clear", int'(frame_err), 0);
        drive(1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    initial begin
        rst           = 1'b1;
        cfg_offset    = 8'h00;
        cfg_fixed_en  = 1'b0;
        cfg_fixed_thr = 8'h00;
        in_if.vsync   = 1'b0;
        in_if.href    = 1'b0;
        in_if.pix     = 8'h00;
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 8'h00, 8'h00);
        chk("rst_vsync", int'(out_if.vsync), 0);
        chk("rst_href", int'(out_if.href), 0);
        chk("rst_bin", int'(out_if.pix), 0);
        chk("rst_thr", int'(thr_cur), 8'h80);
        chk("rst_err", int'(frame_err), 0);
        rst = 1'b0;
        drive(1'b0, 1'b0, 8'h00, 8'h00);

        // 0x81 against the reset threshold of 0x80
        frame(8'h81, 8'h81, 8'hFF, 8'hFF, 64);
        end_frame(8'h80, 8'h81, 1'b0);

        // adaptive: mean 0x40 + 0x10
        cfg_offset = 8'h10;
        frame(8'h40, 8'h40, 8'h00, 8'h00, 64);
        end_frame(8'h81, 8'h50, 1'b0);
        frame(8'h51, 8'h50, 8'hFF, 8'h00, 64);
        end_frame(8'h50, 8'h60, 1'b0);

        // clamp at 255 and strict compare at full scale
        frame(8'hF8, 8'hF8, 8'hFF, 8'hFF, 64);
        end_frame(8'h60, 8'hFF, 1'b0);
        frame(8'hFF, 8'hFF, 8'h00, 8'h00, 64);
        end_frame(8'hFF, 8'hFF, 1'b0);

        // short frame
        frame(8'h10, 8'h10, 8'h00, 8'h00, 63);
        end_frame(8'hFF, 8'hFF, 1'b1);

        // fixed threshold overrides compare but adaptation continues
        cfg_offset    = 8'h00;
        cfg_fixed_en  = 1'b1;
        cfg_fixed_thr = 8'h20;
        frame(8'h20, 8'h21, 8'h00, 8'hFF, 64);
        end_frame(8'hFF, 8'h20, 1'b0);
        frame(8'h30, 8'h30, 8'hFF, 8'hFF, 64);
        end_frame(8'h20, 8'h30, 1'b0);
        cfg_fixed_en = 1'b0;

        // href outside vsync: binarized but not accumulated
        drive(1'b0, 1'b1, 8'h31, 8'hFF);
        drive(1'b0, 1'b1, 8'h30, 8'h00);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 8'h00, 8'h00);
        chk("nov_thr", int'(thr_cur), 8'h30);
        chk("nov_err", int'(frame_err), 0);

        frame(8'h40, 8'h40, 8'hFF, 8'hFF, 64);
        end_frame(8'h30, 8'h40, 1'b0);

        // mid-frame reset with vsync held high
        frame(8'h50, 8'h50, 8'hFF, 8'hFF, 20);
        rst = 1'b1;
        drive(1'b1, 1'b1, 8'h50, 8'hFF);
        chk("mrst_vsync", int'(out_if.vsync), 0);
        chk("mrst_href", int'(out_if.href), 0);
        chk("mrst_bin", int'(out_if.pix), 0);
        chk("mrst_thr", int'(thr_cur), 8'h80);
        chk("mrst_err", int'(frame_err), 0);
        rst = 1'b0;
        for (int i = 0; i < 30; i++) drive(1'b1, 1'b1, 8'h90, 8'hFF);
        end_frame(8'h80, 8'h80, 1'b1);

        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 8'h00, 8'h00);
        chk("sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
